// File: rtl/fcp_pkg.sv
// Shared FCP definitions: voltage level codes and the voltage-step sequencer state encoding.
package fcp_pkg;

  localparam int unsigned VOLT_W = 2;

  localparam logic [VOLT_W-1:0] VOLT_5V   = 2'b00;
  localparam logic [VOLT_W-1:0] VOLT_9V   = 2'b01;
  localparam logic [VOLT_W-1:0] VOLT_12V  = 2'b10;
  localparam logic [VOLT_W-1:0] VOLT_RSVD = 2'b11;

  typedef enum logic [1:0] {
    VSTEP_IDLE   = 2'd0,
    VSTEP_PULSE  = 2'd1,
    VSTEP_GAP    = 2'd2,
    VSTEP_SETTLE = 2'd3
  } vstep_state_e;

  // Reserved or unsupported requests hold the applied level; a master reset forces 5V.
  function automatic logic [VOLT_W-1:0] vstep_eff_target(
    input logic [VOLT_W-1:0] req,
    input logic              support_12v,
    input logic [VOLT_W-1:0] cur,
    input logic              force_5v
  );
    logic [VOLT_W-1:0] tgt;
    tgt = req;
    if (force_5v)                             tgt = VOLT_5V;
    else if (req == VOLT_RSVD)                tgt = cur;
    else if (req == VOLT_12V && !support_12v) tgt = cur;
    return tgt;
  endfunction

endpackage

// File: rtl/fcp_dwell_timer.sv
// Loadable down-counter; expire_c is high during the last cycle of a started dwell.
module fcp_dwell_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  assign expire_c = run_q && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      cnt_d = load;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/fcp_volt_step_ctrl.sv
// Walks the power converter one level at a time toward the requested voltage with timed UP/DN pulses.
// Define FCP_VSTEP_SETTLE_EN to add a settle dwell after each completed step.
module fcp_volt_step_ctrl
  import fcp_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = 25,
  parameter int unsigned GAP_CYCLES    = 25,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [VOLT_W-1:0] target_volt,
  input  logic              is_support_12v,
  input  logic              reset_from_master,
  output logic              up_volt,
  output logic              dn_volt,
  output logic [VOLT_W-1:0] cur_volt,
  output logic              busy,
  output logic              step_done
);

  vstep_state_e      state_q, state_d;
  logic              dir_up_q, dir_up_d;
  logic [VOLT_W-1:0] cur_q, cur_d;
  logic              up_q, up_d;
  logic              dn_q, dn_d;
  logic              busy_q, busy_d;
  logic              step_done_q, step_done_d;
  logic              ovr_q, ovr_d;
  logic [VOLT_W-1:0] ovr_tgt_q, ovr_tgt_d;

  logic              ovr_active_c;
  logic [VOLT_W-1:0] eff_tgt_c;
  logic              tmr_start_c;
  logic [CNT_W-1:0]  tmr_load_c;
  logic              tmr_expire_c;

  // Override holds until target_volt first departs from the value seen when it was raised.
  always_comb begin
    ovr_active_c = reset_from_master || (ovr_q && (target_volt == ovr_tgt_q));
    ovr_d        = ovr_active_c;
    ovr_tgt_d    = reset_from_master ? target_volt : ovr_tgt_q;
    eff_tgt_c    = vstep_eff_target(target_volt, is_support_12v, cur_q, ovr_active_c);
  end

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    cur_d       = cur_q;
    step_done_d = 1'b0;
    case (state_q)
      VSTEP_IDLE: begin
        if (eff_tgt_c > cur_q) begin
          state_d  = VSTEP_PULSE;
          dir_up_d = 1'b1;
        end else if (eff_tgt_c < cur_q) begin
          state_d  = VSTEP_PULSE;
          dir_up_d = 1'b0;
        end
      end
      VSTEP_PULSE: begin
        if (tmr_expire_c) state_d = VSTEP_GAP;
      end
      VSTEP_GAP: begin
        if (tmr_expire_c) begin
          cur_d       = dir_up_q ? (cur_q + 2'd1) : (cur_q - 2'd1);
          step_done_d = 1'b1;
`ifdef FCP_VSTEP_SETTLE_EN
          state_d     = VSTEP_SETTLE;
`else
          state_d     = VSTEP_IDLE;
`endif
        end
      end
      VSTEP_SETTLE: begin
        if (tmr_expire_c) state_d = VSTEP_IDLE;
      end
      default: state_d = VSTEP_IDLE;
    endcase
    up_d   = (state_d == VSTEP_PULSE) && dir_up_d;
    dn_d   = (state_d == VSTEP_PULSE) && !dir_up_d;
    busy_d = (state_d != VSTEP_IDLE);
  end

  // One dwell timer, reloaded with the length of whichever timed state is being entered.
  always_comb begin
    tmr_start_c = (state_d != state_q) && (state_d != VSTEP_IDLE);
    case (state_d)
      VSTEP_PULSE:  tmr_load_c = CNT_W'(PULSE_CYCLES - 1);
      VSTEP_GAP:    tmr_load_c = CNT_W'(GAP_CYCLES - 1);
      VSTEP_SETTLE: tmr_load_c = CNT_W'(SETTLE_CYCLES - 1);
      default:      tmr_load_c = '0;
    endcase
  end

  fcp_dwell_timer #(
    .CNT_W(CNT_W)
  ) u_dwell_timer (
    .clk     (clk),
    .rstn    (rstn),
    .start   (tmr_start_c),
    .load    (tmr_load_c),
    .expire_c(tmr_expire_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= VSTEP_IDLE;
      dir_up_q    <= 1'b0;
      cur_q       <= VOLT_5V;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      ovr_q       <= 1'b0;
      ovr_tgt_q   <= VOLT_5V;
    end else begin
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      cur_q       <= cur_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      ovr_q       <= ovr_d;
      ovr_tgt_q   <= ovr_tgt_d;
    end
  end

  assign up_volt   = up_q;
  assign dn_volt   = dn_q;
  assign cur_volt  = cur_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;

endmodule

// File: tb/tb_fcp_volt_step_ctrl.sv
// Directed bench for fcp_volt_step_ctrl: vector table of target requests plus timing/override/reset sequences.
module tb_fcp_volt_step_ctrl;

  localparam int unsigned P = 25;
  localparam int unsigned G = 25;
  localparam int unsigned S = 40;
`ifdef FCP_VSTEP_SETTLE_EN
  localparam int STEP = P + G + S + 1;
`else
  localparam int STEP = P + G + 1;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] target_volt;
  logic       is_support_12v;
  logic       reset_from_master;
  logic       up_volt, dn_volt, busy, step_done;
  logic [1:0] cur_volt;

  fcp_volt_step_ctrl #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .SETTLE_CYCLES(S),
    .CNT_W        (16)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .target_volt      (target_volt),
    .is_support_12v   (is_support_12v),
    .reset_from_master(reset_from_master),
    .up_volt          (up_volt),
    .dn_volt          (dn_volt),
    .cur_volt         (cur_volt),
    .busy             (busy),
    .step_done        (step_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor sampled on the falling edge.
  int up_run = 0, dn_run = 0, up_pulses = 0, dn_pulses = 0;
  int sd_cnt = 0, both_err = 0, width_err = 0;

  always @(negedge clk) begin
    if (up_volt && dn_volt) both_err++;
    if (up_volt) up_run++;
    else if (up_run != 0) begin
      up_pulses++;
      if (up_run != int'(P)) width_err++;
      up_run = 0;
    end
    if (dn_volt) dn_run++;
    else if (dn_run != 0) begin
      dn_pulses++;
      if (dn_run != int'(P)) width_err++;
      dn_run = 0;
    end
    if (step_done) sd_cnt++;
  end

  task automatic clr_mon();
    up_run = 0; dn_run = 0; up_pulses = 0; dn_pulses = 0;
    sd_cnt = 0; both_err = 0; width_err = 0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] tv;
    logic       supp;
    int         exp_up;
    int         exp_dn;
    logic [1:0] exp_cur;
  } vec_t;

  vec_t vecs[10];

  logic up_a[STEP+2];
  logic sd_a[STEP+2];
  logic busy_a[STEP+2];
  logic [1:0] cur_a[STEP+2];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequence starts from cur=01 (left there by the timing sequence).
    vecs[0] = '{2'b10, 1'b0, 0, 0, 2'b01};
    vecs[1] = '{2'b10, 1'b1, 1, 0, 2'b10};
    vecs[2] = '{2'b11, 1'b1, 0, 0, 2'b10};
    vecs[3] = '{2'b00, 1'b1, 0, 2, 2'b00};
    vecs[4] = '{2'b10, 1'b1, 2, 0, 2'b10};
    vecs[5] = '{2'b01, 1'b1, 0, 1, 2'b01};
    vecs[6] = '{2'b10, 1'b0, 0, 0, 2'b01};
    vecs[7] = '{2'b00, 1'b0, 0, 1, 2'b00};
    vecs[8] = '{2'b10, 1'b0, 0, 0, 2'b00};
    vecs[9] = '{2'b11, 1'b1, 0, 0, 2'b00};

    rstn = 1'b0; target_volt = 2'b00; is_support_12v = 1'b1; reset_from_master = 1'b0;
    wait_cyc(3);
    chk("rst_up",   int'(up_volt),   0);
    chk("rst_dn",   int'(dn_volt),   0);
    chk("rst_cur",  int'(cur_volt),  0);
    chk("rst_busy", int'(busy),      0);
    chk("rst_sd",   int'(step_done), 0);
    rstn = 1'b1;
    wait_cyc(3);
    chk("idle_busy", int'(busy), 0);

    // Exact timing of one 00->01 step.
    clr_mon();
    target_volt = 2'b01;
    for (int k = 1; k <= STEP + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      up_a[k] = up_volt; sd_a[k] = step_done; busy_a[k] = busy; cur_a[k] = cur_volt;
    end
    #1;
    chk("t_up_first",     int'(up_a[1]),         1);
    chk("t_busy_first",   int'(busy_a[1]),       1);
    chk("t_up_last",      int'(up_a[P]),         1);
    chk("t_up_off",       int'(up_a[P+1]),       0);
    chk("t_sd_early",     int'(sd_a[P+G]),       0);
    chk("t_cur_before",   int'(cur_a[P+G]),      0);
    chk("t_sd_pulse",     int'(sd_a[P+G+1]),     1);
    chk("t_cur_after",    int'(cur_a[P+G+1]),    1);
    chk("t_busy_end",     int'(busy_a[STEP-1]),  1);
    chk("t_busy_idle",    int'(busy_a[STEP]),    0);
    chk("t_sd_count",     sd_cnt,                1);
    chk("t_up_pulses",    up_pulses,             1);

    for (int i = 0; i < 10; i++) begin
      clr_mon();
      target_volt    = vecs[i].tv;
      is_support_12v = vecs[i].supp;
      wait_cyc(2 * STEP + 10);
      chk($sformatf("v%0d_up", i),    up_pulses,      vecs[i].exp_up);
      chk($sformatf("v%0d_dn", i),    dn_pulses,      vecs[i].exp_dn);
      chk($sformatf("v%0d_sd", i),    sd_cnt,         vecs[i].exp_up + vecs[i].exp_dn);
      chk($sformatf("v%0d_cur", i),   int'(cur_volt), int'(vecs[i].exp_cur));
      chk($sformatf("v%0d_busy", i),  int'(busy),     0);
      chk($sformatf("v%0d_both", i),  both_err,       0);
      chk($sformatf("v%0d_width", i), width_err,      0);
    end

    // Target drops back mid-pulse: step completes, then one step back down.
    target_volt = 2'b00; is_support_12v = 1'b1;
    wait_cyc(2);
    clr_mon();
    target_volt = 2'b01;
    wait_cyc(10);
    chk("mid_up_high", int'(up_volt), 1);
    target_volt = 2'b00;
    wait_cyc(3 * STEP);
    chk("mid_up",    up_pulses,      1);
    chk("mid_dn",    dn_pulses,      1);
    chk("mid_sd",    sd_cnt,         2);
    chk("mid_cur",   int'(cur_volt), 0);
    chk("mid_width", width_err,      0);

    // Master reset override with target held at 01.
    target_volt = 2'b01;
    wait_cyc(STEP + 5);
    chk("ovr_pre_cur", int'(cur_volt), 1);
    clr_mon();
    reset_from_master = 1'b1;
    wait_cyc(1);
    reset_from_master = 1'b0;
    wait_cyc(2 * STEP + 10);
    chk("ovr_dn",  dn_pulses,      1);
    chk("ovr_up",  up_pulses,      0);
    chk("ovr_cur", int'(cur_volt), 0);
    target_volt = 2'b00;
    wait_cyc(3);
    clr_mon();
    target_volt = 2'b01;
    wait_cyc(STEP + 5);
    chk("ovr_rel_cur", int'(cur_volt), 1);
    chk("ovr_rel_up",  up_pulses,      1);

    // Override and target change in the same cycle: override wins.
    clr_mon();
    reset_from_master = 1'b1; target_volt = 2'b10; is_support_12v = 1'b1;
    wait_cyc(1);
    reset_from_master = 1'b0;
    wait_cyc(3 * STEP);
    chk("ovr_same_cur", int'(cur_volt), 0);
    chk("ovr_same_up",  up_pulses,      0);
    chk("ovr_same_dn",  dn_pulses,      1);

    // Asynchronous reset mid-pulse.
    target_volt = 2'b01;
    wait_cyc(5);
    chk("ar_up_high", int'(up_volt), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_up",   int'(up_volt),  0);
    chk("ar_cur",  int'(cur_volt), 0);
    chk("ar_busy", int'(busy),     0);
    wait_cyc(2);
    target_volt = 2'b11;
    rstn = 1'b1;
    clr_mon();
    wait_cyc(2 * STEP);
    chk("rsvd_up",   up_pulses,      0);
    chk("rsvd_dn",   dn_pulses,      0);
    chk("rsvd_cur",  int'(cur_volt), 0);
    chk("rsvd_busy", int'(busy),     0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcp_volt_step_ctrl.md
# fcp_volt_step_ctrl

Voltage transition sequencer between the FCP logical layer and the external power-converter control pins. Takes the 2-bit requested output-voltage code and walks the converter one discrete level at a time (5V↔9V↔12V) by emitting timed UP/DN pulses with an inter-step gap and a settle dwell. Reports the currently applied level back so VOUT_STATUS can reflect real hardware state.

## Interface
Parameters:
- PULSE_CYCLES, 25: width of each up_volt/dn_volt pulse, in clk cycles (≥1).
- GAP_CYCLES, 25: low time after each pulse before the next action (≥1).
- SETTLE_CYCLES, 1000: dwell after each completed step (≥1; used only with FCP_VSTEP_SETTLE_EN).
- CNT_W, 16: dwell counter width; must hold max(PULSE,GAP,SETTLE)_CYCLES.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- target_volt  in  2  requested level: 00=5V, 01=9V, 10=12V, 11=reserved.
- is_support_12v  in  1  12V level permitted.
- reset_from_master  in  1  single-cycle; forces the target to 5V.
- up_volt  out  1  converter step-up pulse.
- dn_volt  out  1  converter step-down pulse.
- cur_volt  out  2  level currently applied (same encoding).
- busy  out  1  high whenever state ≠ IDLE.
- step_done  out  1  single-cycle pulse when cur_volt updates.

## Operation
- Effective target: target_volt, except 11 → hold cur_volt, and 10 with is_support_12v=0 → hold cur_volt. Override flag set by reset_from_master forces effective target 00; flag clears on the first cycle target_volt differs from its value at override set.
- States: IDLE, PULSE, GAP, SETTLE.
- IDLE: if effective target > cur_volt → PULSE, dir=up; if < → PULSE, dir=down; else stay. Direction latched on entry to PULSE.
- PULSE: up_volt (dir=up) or dn_volt (dir=down) high for exactly PULSE_CYCLES, then → GAP.
- GAP: both pulses low for GAP_CYCLES; at exit cur_volt ← cur_volt ±1, step_done=1; → SETTLE.
- SETTLE: wait SETTLE_CYCLES, → IDLE. Target re-evaluated only in IDLE, so 5V→12V is two full steps.
- Target change mid-step: current step always completes; no abort, no pulse truncation.
- up_volt and dn_volt never high in the same cycle.
- Reset values: up_volt=0, dn_volt=0, cur_volt=00, busy=0, step_done=0, state=IDLE, override=0.
- Asynchronous reset mid-pulse drops pulses immediately; cur_volt returns to 00 (converter is reset with the same POR).

## Timing
- Target mismatch seen in IDLE at cycle N → up/dn high cycles N+1 … N+PULSE_CYCLES.
- step_done / cur_volt update at cycle N+PULSE_CYCLES+GAP_CYCLES (registered, visible next edge).
- One step total: PULSE_CYCLES+GAP_CYCLES+SETTLE_CYCLES+1 cycles from IDLE to IDLE.
- busy rises on the cycle up/dn rises; falls on return to IDLE.
- reset_from_master and target_volt change in the same cycle: override wins (target 00).

## Configuration
- FCP_VSTEP_SETTLE_EN defined: SETTLE state present as above.
- Not defined: GAP exits directly to IDLE; SETTLE_CYCLES unused; step length PULSE_CYCLES+GAP_CYCLES+1.

## Structure
- Shared package fcp_pkg: voltage codes (VOLT_5V, VOLT_9V, VOLT_12V, VOLT_RSVD) and the vstep state encoding; used also by the logical layer.
- One sub-module: fcp_dwell_timer (CNT_W down-counter, load value + start, expire pulse), instanced once and reloaded per state.

## Test plan
- Reset, target 01 → one up pulse of 25 cycles, 25-cycle gap, cur_volt=01, step_done once, busy low after settle.
- Target 10, is_support_12v=1, from 00 → two up pulses, cur_volt 00→01→10; with is_support_12v=0 → no pulses, cur_volt stays 00.
- At 10, target 00 → two dn pulses, cur_volt 10→01→00; up_volt never asserted.
- Target 01→00 mid-PULSE of a 00→01 step → step completes to 01, then one dn pulse back to 00.
- At 01, reset_from_master pulse with target_volt held 01 → one dn pulse, cur_volt=00, stays 00 until target_volt changes.
- Target 11 → no activity; rstn asserted mid-pulse → up_volt drops same cycle, cur_volt=00.
